// File: rtl/elastic_pipe_reg_if.sv
// Handshake bundle for elastic_pipe_reg.
//   flush              : invalidate every stage at the next edge
//   in_valid/in_data   : upstream offer; in_ready is the accept strobe
//   out_valid/out_data : last-stage payload; out_ready is the downstream accept
// master = environment driving the pipe, slave = the pipe itself.
interface elastic_pipe_reg_if #(parameter int WIDTH = 1);
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (output flush, in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  flush, in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline register: DEPTH stages, each with a valid bit and a payload.
// Readiness ripples combinationally from the output side back to the input,
// so empty stages are collapsed without a bubble penalty.
// Ports:
//   clk   : clock, all state on posedge
//   rst   : synchronous active-high reset (wins over flush and handshakes)
//   bus   : handshake bundle (slave side), see elastic_pipe_reg_if
//   count : number of valid stages, 0..DEPTH
module elastic_pipe_reg #(
  parameter int               WIDTH      = 1,
  parameter int               DEPTH      = 2,
  parameter logic [WIDTH-1:0] INIT       = {WIDTH{1'b0}},
  parameter bit               DATA_RESET = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  elastic_pipe_reg_if.slave          bus,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0]            v_q, v_d, rdy, up_v;
  logic [DEPTH-1:0][WIDTH-1:0] p_q, p_d, up_p;

  // Upstream view of each stage: the pipe input for stage 0, else the previous stage.
  for (genvar k = 0; k < DEPTH; k++) begin : g_up
    if (k == 0) begin : g_first
      assign up_v[k] = bus.in_valid;
      assign up_p[k] = bus.in_data;
    end else begin : g_rest
      assign up_v[k] = v_q[k-1];
      assign up_p[k] = p_q[k-1];
    end
  end

  // A stage can take new content if it is empty or its successor can drain it.
  always_comb begin
    rdy = '0;
    rdy[DEPTH-1] = !v_q[DEPTH-1] | bus.out_ready;
    for (int k = DEPTH-2; k >= 0; k--)
      rdy[k] = !v_q[k] | rdy[k+1];
  end

  // Payload only moves with a valid token, so bubbles never clobber data.
  always_comb begin
    v_d = v_q;
    p_d = p_q;
    if (bus.flush) begin
      v_d = '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (rdy[k]) begin
          v_d[k] = up_v[k];
          if (up_v[k]) p_d[k] = up_p[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      if (DATA_RESET) p_q <= {DEPTH{INIT}};
    end else begin
      v_q <= v_d;
      p_q <= p_d;
    end
  end

  always_comb begin
    count = '0;
    for (int k = 0; k < DEPTH; k++)
      count = count + CW'(v_q[k]);
  end

  assign bus.in_ready  = rdy[0] & !bus.flush & !rst;
  assign bus.out_valid = v_q[DEPTH-1];
  assign bus.out_data  = p_q[DEPTH-1];
endmodule
